div_arbiter: RTL and testbench

Round-robin scheduler that shares one serial (restoring, one bit per cycle) unsigned divider among NUM_REQ requesters in the accumulate/average datapath. Each requester presents a dividend/divisor pair on a valid/ready channel. The arbiter grants one request at a time, sequences the divider through WIDTH iterations, and returns the quotient and remainder tagged with the requester index on a single response channel with backpressure.

---
 rtl/div_arbiter_pkg.sv | 13 +
 rtl/div_serial_core.sv | 56 +++++
 rtl/div_arbiter.sv | 111 +++++++++++
 tb/tb_div_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/div_arbiter_pkg.sv
// div_arbiter_pkg: shared FSM state, default sizes and id-width helper for div_arbiter.
package div_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_NUM_REQ = 4;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/div_serial_core.sv
// div_serial_core: restoring unsigned divider, one quotient bit per cycle, MSB first.
// The first iteration runs on the start edge, so done rises WIDTH-1 edges later.
module div_serial_core
    import div_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q, cur_r, cur_q, cur_d, rem_d, quo_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   sh;
    logic [WIDTH+1:0] diff;
    logic             step;

    always_comb begin
        cur_r = start ? '0 : rem_q;
        cur_q = start ? dividend : quo_q;
        cur_d = start ? divisor : dvs_q;
        sh    = {cur_r, cur_q[WIDTH-1]};
        // Top bit of diff is the borrow; the restored value always fits WIDTH bits.
        diff  = {1'b0, sh} - {2'b00, cur_d};
        rem_d = diff[WIDTH+1] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_d = {cur_q[WIDTH-2:0], ~diff[WIDTH+1]};
    end

    assign step      = start || cnt_q != '0;
    assign done      = cnt_q == '0;
    assign quotient  = quo_q;
    assign remainder = rem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (step) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= cur_d;
            cnt_q <= start ? CW'(WIDTH - 1) : cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin share of one serial divider among NUM_REQ requesters.
// Define DIV_ARBITER_DBZ_EN to answer zero divisors immediately with rsp_dbz set.
module div_arbiter
    import div_arbiter_pkg::*;
#(
    parameter int  NUM_REQ = DEF_NUM_REQ,
    parameter int  WIDTH   = DEF_WIDTH,
    localparam int IW      = id_w(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
    input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IW-1:0]            rsp_id,
    output logic [WIDTH-1:0]         rsp_quotient,
    output logic [WIDTH-1:0]         rsp_remainder,
    output logic                     rsp_dbz,
    output logic                     busy
);

`ifdef DIV_ARBITER_DBZ_EN
    localparam bit DBZ_EN = 1'b1;
`else
    localparam bit DBZ_EN = 1'b0;
`endif

    state_e                        state_q;
    logic [IW-1:0]                 rr_q, rr_d, win, idx, id_q;
    logic [WIDTH-1:0]              quo_q, rem_q, sel_dvd, sel_dvs, core_quo, core_rem;
    logic [NUM_REQ-1:0][WIDTH-1:0] dvd_a, dvs_a;
    logic                          dbz_q, found, take, dbz_go, start, core_done;

    // Descending scan so the lowest offset from rr_q is the last, winning, write.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IW'((int'(rr_q) + k) % NUM_REQ);
            if (req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign dvd_a   = req_dividend;
    assign dvs_a   = req_divisor;
    assign sel_dvd = dvd_a[win];
    assign sel_dvs = dvs_a[win];
    assign rr_d    = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    assign take    = state_q == IDLE && found;
    assign dbz_go  = DBZ_EN && sel_dvs == '0;
    assign start   = take && !dbz_go;

    assign req_ready     = (rst_n && take) ? (NUM_REQ'(1) << win) : '0;
    assign rsp_valid     = state_q == RESP;
    assign busy          = state_q != IDLE;
    assign rsp_id        = id_q;
    assign rsp_quotient  = quo_q;
    assign rsp_remainder = rem_q;
    assign rsp_dbz       = dbz_q;

    div_serial_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (sel_dvd),
        .divisor   (sel_dvs),
        .done      (core_done),
        .quotient  (core_quo),
        .remainder (core_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (take) begin
                    id_q    <= win;
                    rr_q    <= rr_d;
                    state_q <= dbz_go ? RESP : BUSY;
                    if (dbz_go) begin
                        quo_q <= '1;
                        rem_q <= sel_dvd;
                        dbz_q <= 1'b1;
                    end
                end
                BUSY: if (core_done) begin
                    state_q <= RESP;
                    quo_q   <= core_quo;
                    rem_q   <= core_rem;
                    dbz_q   <= 1'b0;
                end
                RESP: if (rsp_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed self-checking bench for div_arbiter (default 4 x 32-bit).
module tb_div_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_ready;
    logic [N*W-1:0] req_dividend, req_divisor;
    logic           rsp_valid, rsp_ready, rsp_dbz, busy;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_quotient, rsp_remainder;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    div_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_dbz       (rsp_dbz),
        .busy          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        req_dividend[id*W +: W] = a;
        req_divisor[id*W +: W]  = b;
    endtask

    // Present a lone request, check the zero-latency grant, drop valid after the accept edge.
    task automatic request(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        set_ops(id, a, b);
        req_valid[id] = 1'b1;
        #1;
        chk("grant", {60'd0, req_ready}, 64'd1 << id);
        @(posedge clk);
        #1 req_valid[id] = 1'b0;
    endtask

    // Latency counts negedges from the accept cycle to the first rsp_valid cycle.
    task automatic expect_rsp(input string tag, input int id, input logic [W-1:0] q,
                              input logic [W-1:0] r, input logic dbz, input int lat_exp);
        int lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (rsp_valid !== 1'b1 && lat < 200);
        chk({tag, "_lat"}, lat, lat_exp);
        chk({tag, "_id"}, rsp_id, id);
        chk({tag, "_quo"}, rsp_quotient, q);
        chk({tag, "_rem"}, rsp_remainder, r);
        chk({tag, "_dbz"}, rsp_dbz, dbz);
    endtask

    initial begin
        int last;
        int n;
        int exp_q[4];
        int exp_r[4];
        exp_q = '{33, 50, 60, 67};
        exp_r = '{1, 1, 2, 1};
        rst_n        = 1'b0;
        req_valid    = '0;
        rsp_ready    = 1'b1;
        req_dividend = '0;
        req_divisor  = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_quo", rsp_quotient, 0);
        chk("rst_rem", rsp_remainder, 0);
        chk("rst_dbz", rsp_dbz, 0);
        req_valid = '1;
        #1 chk("rst_ready", req_ready, 0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // All four requesters held valid: strict rotation 0,1,2,3,0 at 34-cycle spacing.
        @(negedge clk);
        for (int i = 0; i < N; i++) set_ops(i, 100 * (i + 1) + i, i + 3);
        req_valid = '1;
        #1;
        last = 0;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while ((req_ready & req_valid) == '0 && n < 100) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("rot_grant", {60'd0, req_ready}, 64'd1 << (g % 4));
            if (g > 0) chk("rot_gap", cyc - last, 34);
            last = cyc;
            if (g == 4) begin
                @(posedge clk);
                #1 req_valid = '0;
            end
            expect_rsp("rot", g % 4, exp_q[g % 4], exp_r[g % 4], 1'b0, 33);
        end

        request(0, 100, 7);
        expect_rsp("single", 0, 14, 2, 1'b0, 33);
        request(1, 32'hFFFF_FFFF, 1);
        expect_rsp("max_by1", 1, 32'hFFFF_FFFF, 0, 1'b0, 33);
        request(2, 5, 9);
        expect_rsp("small", 2, 0, 5, 1'b0, 33);
        request(3, 32'h8000_0000, 32'hFFFF_FFFF);
        expect_rsp("big_dvs", 3, 0, 32'h8000_0000, 1'b0, 33);
        request(0, 1234, 0);
`ifdef DIV_ARBITER_DBZ_EN
        expect_rsp("dbz", 0, 32'hFFFF_FFFF, 1234, 1'b1, 1);
`else
        expect_rsp("dbz", 0, 32'hFFFF_FFFF, 1234, 1'b0, 33);
`endif

        // Backpressure: response held for 10 cycles while requester 2 waits.
        @(negedge clk);
        rsp_ready = 1'b0;
        request(1, 7, 2);
        expect_rsp("bp", 1, 3, 1, 1'b0, 33);
        set_ops(2, 9, 3);
        req_valid[2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("bp_valid", rsp_valid, 1);
            chk("bp_quo", rsp_quotient, 3);
            chk("bp_rem", rsp_remainder, 1);
            chk("bp_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_regrant", req_ready, 4'b0100);
        chk("bp_idle", busy, 0);
        @(posedge clk);
        #1 req_valid[2] = 1'b0;
        expect_rsp("bp2", 2, 3, 0, 1'b0, 33);

        // Reset while requester 2 is in flight; pointer must restart at 0.
        request(2, 50, 5);
        repeat (10) @(negedge clk);
        #1 chk("mid_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_valid", rsp_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ready", req_ready, 0);
        chk("mrst_id", rsp_id, 0);
        chk("mrst_quo", rsp_quotient, 0);
        chk("mrst_rem", rsp_remainder, 0);
        @(negedge clk);
        rst_n = 1'b1;
        set_ops(2, 50, 5);
        set_ops(3, 11, 4);
        req_valid = 4'b1100;
        #1 chk("rr_reset", req_ready, 4'b0100);
        @(posedge clk);
        #1 req_valid[2] = 1'b0;
        expect_rsp("post_rst", 2, 10, 0, 1'b0, 33);
        @(negedge clk);
        #1 chk("next3", req_ready, 4'b1000);
        @(posedge clk);
        #1 req_valid[3] = 1'b0;
        expect_rsp("r3", 3, 2, 3, 1'b0, 33);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
